// File: rtl/div23_pkg.sv
// Shared constants, FSM state type and digit-count helper for the divide-by-23 family.
package div23_pkg;

  localparam int unsigned DIVISOR    = 23;
  localparam int unsigned REM_W      = 5;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned n_digits(input int unsigned digit_w,
                                           input int unsigned data_w = DEF_DATA_W);
    return data_w / digit_w;
  endfunction

endpackage

// File: rtl/mul23_reconstruct_if.sv
// Operand/result handshake bundle for mul23_reconstruct.
interface mul23_reconstruct_if #(
  parameter int unsigned DATA_W = div23_pkg::DEF_DATA_W
);
  import div23_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_q;
  logic [REM_W-1:0]  in_r;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_x;
  logic              out_ovf;
  logic              out_err;

  modport master (
    output in_valid, in_q, in_r, out_ready,
    input  in_ready, out_valid, out_x, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_q, in_r, out_ready,
    output in_ready, out_valid, out_x, out_ovf, out_err
  );

endinterface

// File: rtl/mul23_digit.sv
// One digit step of x = 23*q + r: sum = 23*d + carry, split into low digit and carry.
module mul23_digit
  import div23_pkg::*;
#(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] d_i,
  input  logic [REM_W-1:0]   carry_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic [REM_W-1:0]   carry_o
);

  localparam int unsigned SUM_W = DIGIT_W + REM_W;

  logic [SUM_W-1:0] sum_c;

  assign sum_c   = SUM_W'(DIVISOR) * SUM_W'(d_i) + SUM_W'(carry_i);
  assign digit_o = sum_c[DIGIT_W-1:0];
  assign carry_o = sum_c[SUM_W-1:DIGIT_W];

endmodule

// File: rtl/mul23_reconstruct.sv
// Digit-serial x = 23*q + r rebuilder, LSB-first, one DIGIT_W-bit digit per cycle.
// Optional range check on in_r enabled by defining MUL23_RANGE_CHECK_EN.
module mul23_reconstruct
  import div23_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mul23_reconstruct_if.slave  bus
);

  localparam int unsigned N_DIGITS = n_digits(DIGIT_W, DATA_W);
  localparam int unsigned CNT_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  if (!(DIGIT_W == 1 || DIGIT_W == 2 || DIGIT_W == 4 || DIGIT_W == 8) ||
      (DATA_W % DIGIT_W) != 0) begin : g_bad_param
    $error("mul23_reconstruct: illegal DIGIT_W/DATA_W combination");
  end

  state_e            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_x_q;
  logic              out_ovf_q;
  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] res_d;
  logic [REM_W-1:0]  carry_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [DIGIT_W-1:0] digit_c;
  logic [REM_W-1:0]   carry_c;
  logic               accept_c;
  logic               last_c;
  logic               release_c;

  mul23_digit #(.DIGIT_W(DIGIT_W)) u_digit (
    .d_i     (q_q[DIGIT_W-1:0]),
    .carry_i (carry_q),
    .digit_o (digit_c),
    .carry_o (carry_c)
  );

  // Result fills from the MSB side so the first digit lands at bit 0 after N_DIGITS shifts.
  assign res_d     = {digit_c, res_q[DATA_W-1:DIGIT_W]};
  assign accept_c  = (state_q == ST_IDLE) && bus.in_valid && in_ready_q;
  assign last_c    = (state_q == ST_RUN) && (cnt_q == CNT_W'(N_DIGITS - 1));
  assign release_c = (state_q == ST_DONE) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_ovf_q   <= 1'b0;
      q_q         <= '0;
      res_q       <= '0;
      carry_q     <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept_c) begin
            in_ready_q <= 1'b0;
            q_q        <= bus.in_q;
            carry_q    <= bus.in_r;
            res_q      <= '0;
            cnt_q      <= '0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          q_q     <= q_q >> DIGIT_W;
          res_q   <= res_d;
          carry_q <= carry_c;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_c) begin
            out_valid_q <= 1'b1;
            out_x_q     <= res_d;
            out_ovf_q   <= (carry_c != '0);
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (release_c) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_ovf   = out_ovf_q;

`ifdef MUL23_RANGE_CHECK_EN
  logic err_q;
  logic out_err_q;

  // Flag captured with the operands, published together with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      if (accept_c) begin
        err_q <= (bus.in_r >= REM_W'(DIVISOR));
      end
      if (last_c) begin
        out_err_q <= err_q;
      end else if (release_c) begin
        out_err_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept_c) begin
      assert (bus.in_r <= REM_W'(DIVISOR - 1))
        else $warning("mul23_reconstruct: remainder %0d out of range", bus.in_r);
    end
  end

  assign bus.out_err = out_err_q;
`else
  assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_mul23_reconstruct.sv
// Directed bench for mul23_reconstruct: reset, arithmetic vectors, digit widths, backpressure, abort.
module tb_mul23_reconstruct;
  import div23_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mul23_reconstruct_if #(.DATA_W(32)) b4 ();
  mul23_reconstruct_if #(.DATA_W(32)) b1 ();
  mul23_reconstruct_if #(.DATA_W(32)) b2 ();
  mul23_reconstruct_if #(.DATA_W(32)) b8 ();

  mul23_reconstruct #(.DATA_W(32), .DIGIT_W(4)) dut   (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  mul23_reconstruct #(.DATA_W(32), .DIGIT_W(1)) dut_1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  mul23_reconstruct #(.DATA_W(32), .DIGIT_W(2)) dut_2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  mul23_reconstruct #(.DATA_W(32), .DIGIT_W(8)) dut_8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  // One transaction on the DIGIT_W=4 instance; returns the DONE outputs and cycles from accept.
  task automatic txn(input logic [31:0] q, input logic [4:0] r,
                     output logic [31:0] x, output logic ovf, output logic err, output int lat);
    int guard = 0;
    while (b4.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    b4.in_valid = 1'b1;
    b4.in_q     = q;
    b4.in_r     = r;
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    b4.in_q     = $urandom;
    b4.in_r     = 5'($urandom_range(0, 22));
    lat = 0;
    while (b4.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    x   = b4.out_x;
    ovf = b4.out_ovf;
    err = b4.out_err;
  endtask

  logic [31:0] x;
  logic        ovf;
  logic        err;
  int          lat;
  logic        exp_err_r23;
  int          l1, l2, l4, l8;
  logic [31:0] x1, x2, x4, x8;
  logic        o1, o2, o4, o8;
  int          seen;

  initial begin
`ifdef MUL23_RANGE_CHECK_EN
    exp_err_r23 = 1'b1;
`else
    exp_err_r23 = 1'b0;
`endif
    b4.in_valid = 1'b0; b4.in_q = '0; b4.in_r = '0; b4.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_q = '0; b1.in_r = '0; b1.out_ready = 1'b1;
    b2.in_valid = 1'b0; b2.in_q = '0; b2.in_r = '0; b2.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.in_q = '0; b8.in_r = '0; b8.out_ready = 1'b1;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(b4.in_ready), 32'd0);
    chk("rst out_valid", 32'(b4.out_valid), 32'd0);
    chk("rst out_x", b4.out_x, 32'd0);
    chk("rst out_ovf", 32'(b4.out_ovf), 32'd0);
    chk("rst out_err", 32'(b4.out_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst in_ready", 32'(b4.in_ready), 32'd1);

    txn(32'd0, 5'd0, x, ovf, err, lat);
    chk("q0r0 x", x, 32'h0000_0000);
    chk("q0r0 ovf", 32'(ovf), 32'd0);
    chk("q0r0 err", 32'(err), 32'd0);
    chk("q0r0 latency", 32'(lat), 32'd8);

    txn(32'd1, 5'd22, x, ovf, err, lat);
    chk("q1r22 x", x, 32'd45);
    chk("q1r22 ovf", 32'(ovf), 32'd0);

    txn(32'd186737708, 5'd11, x, ovf, err, lat);
    chk("max-fit x", x, 32'hFFFF_FFFF);
    chk("max-fit ovf", 32'(ovf), 32'd0);

    txn(32'd186737708, 5'd12, x, ovf, err, lat);
    chk("first-ovf x", x, 32'h0000_0000);
    chk("first-ovf ovf", 32'(ovf), 32'd1);

    txn(32'd100, 5'd7, x, ovf, err, lat);
    chk("q100r7 x", x, 32'h0000_0903);
    chk("q100r7 ovf", 32'(ovf), 32'd0);

    // All four digit widths on q=0xFFFFFFFF, accepted on the same edge.
    seen = 0;
    while ((b4.in_ready & b1.in_ready & b2.in_ready & b8.in_ready) !== 1'b1 && seen < 50) begin
      @(posedge clk); #1;
      seen++;
    end
    b4.in_valid = 1'b1; b4.in_q = 32'hFFFF_FFFF; b4.in_r = 5'd0;
    b1.in_valid = 1'b1; b1.in_q = 32'hFFFF_FFFF; b1.in_r = 5'd0;
    b2.in_valid = 1'b1; b2.in_q = 32'hFFFF_FFFF; b2.in_r = 5'd0;
    b8.in_valid = 1'b1; b8.in_q = 32'hFFFF_FFFF; b8.in_r = 5'd0;
    @(posedge clk); #1;
    b4.in_valid = 1'b0; b1.in_valid = 1'b0; b2.in_valid = 1'b0; b8.in_valid = 1'b0;
    l1 = -1; l2 = -1; l4 = -1; l8 = -1;
    x1 = '0; x2 = '0; x4 = '0; x8 = '0;
    o1 = 1'b0; o2 = 1'b0; o4 = 1'b0; o8 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (b1.out_valid === 1'b1 && l1 < 0) begin l1 = c; x1 = b1.out_x; o1 = b1.out_ovf; end
      if (b2.out_valid === 1'b1 && l2 < 0) begin l2 = c; x2 = b2.out_x; o2 = b2.out_ovf; end
      if (b4.out_valid === 1'b1 && l4 < 0) begin l4 = c; x4 = b4.out_x; o4 = b4.out_ovf; end
      if (b8.out_valid === 1'b1 && l8 < 0) begin l8 = c; x8 = b8.out_x; o8 = b8.out_ovf; end
    end
    chk("d1 x", x1, 32'hFFFF_FFE9);
    chk("d1 ovf", 32'(o1), 32'd1);
    chk("d1 latency", 32'(l1), 32'd32);
    chk("d2 x", x2, 32'hFFFF_FFE9);
    chk("d2 ovf", 32'(o2), 32'd1);
    chk("d2 latency", 32'(l2), 32'd16);
    chk("d4 x", x4, 32'hFFFF_FFE9);
    chk("d4 ovf", 32'(o4), 32'd1);
    chk("d4 latency", 32'(l4), 32'd8);
    chk("d8 x", x8, 32'hFFFF_FFE9);
    chk("d8 ovf", 32'(o8), 32'd1);
    chk("d8 latency", 32'(l8), 32'd4);

    // Backpressure in DONE, with a stray in_valid that must be ignored.
    b4.out_ready = 1'b0;
    txn(32'd1000, 5'd3, x, ovf, err, lat);
    chk("bp x", x, 32'h0000_59DB);
    b4.in_valid = 1'b1; b4.in_q = 32'd7; b4.in_r = 5'd0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp hold valid", 32'(b4.out_valid), 32'd1);
      chk("bp hold x", b4.out_x, 32'h0000_59DB);
      chk("bp hold ovf", 32'(b4.out_ovf), 32'd0);
      chk("bp hold in_ready", 32'(b4.in_ready), 32'd0);
    end
    b4.in_valid  = 1'b0;
    b4.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release valid", 32'(b4.out_valid), 32'd0);
    chk("bp release in_ready", 32'(b4.in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp idle in_ready", 32'(b4.in_ready), 32'd1);

    // Abort at count=3 of RUN.
    b4.in_valid = 1'b1; b4.in_q = 32'd12345; b4.in_r = 5'd0;
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(b4.out_valid), 32'd0);
    chk("abort in_ready", 32'(b4.in_ready), 32'd0);
    chk("abort out_x", b4.out_x, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (b4.out_valid !== 1'b0) seen++;
    end
    chk("abort no result", 32'(seen), 32'd0);
    txn(32'd2, 5'd1, x, ovf, err, lat);
    chk("fresh q2r1 x", x, 32'd47);
    chk("fresh q2r1 latency", 32'(lat), 32'd8);

    txn(32'd5, 5'd23, x, ovf, err, lat);
    chk("r23 x", x, 32'd138);
    chk("r23 ovf", 32'(ovf), 32'd0);
    chk("r23 err", 32'(err), 32'(exp_err_r23));

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul23_reconstruct.md
Name: mul23_reconstruct

Overview:
- Inverse companion to the divide-by-23 quotient/remainder datapath.
- Takes a quotient q and remainder r and rebuilds the dividend x = 23*q + r.
- Works digit-serially, LSB first, one DIGIT_W-bit quotient digit per cycle, with a valid/ready handshake on both sides.
- Sits after the constant divider: it serves as a round-trip checker in the verification and self-test paths and as a cheap multiply-by-23 unit.

Parameters:
- DATA_W, 32: width of q and of x.
- DIGIT_W, 4: quotient bits consumed per cycle. Legal values are 1, 2, 4, 8; DATA_W must be divisible by DIGIT_W.
- N_DIGITS, DATA_W/DIGIT_W: derived, not overridable. Number of RUN cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  q/r operands valid.
- in_ready  out  1  block can accept operands.
- in_q  in  DATA_W  quotient.
- in_r  in  5  remainder; legal range 0..22.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_x  out  DATA_W  low DATA_W bits of 23*q + r.
- out_ovf  out  1  23*q + r does not fit in DATA_W bits.
- out_err  out  1  in_r >= 23 (range-check feature only; otherwise tied 0).

Behaviour:
- Reset values: in_ready=0 while rst_n low, 1 in the first cycle after release (IDLE). out_valid=0, out_x=0, out_ovf=0, out_err=0. Internal state: IDLE, carry=0, digit counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch q into a shift register, load carry=in_r, clear the result shift register, set count=0, go to RUN.
- RUN, one digit per cycle, in_ready=0:
  - d = q[DIGIT_W-1:0]
  - s = 23*d + carry, width DIGIT_W+5
  - Shift s[DIGIT_W-1:0] into the result MSB-side; result fills LSB-first, right-shift accumulation.
  - carry = s >> DIGIT_W (5 bits; bounded by 23 for legal r, still fits 5 bits for r<=31).
  - q >>= DIGIT_W; count++.
  - After the cycle with count == N_DIGITS-1, go to DONE.
- DONE:
  - out_valid=1; out_x = result; out_ovf = (final carry != 0).
  - Outputs held stable until out_valid&out_ready, then go to IDLE and drop out_valid.
- Latency: operands accepted at edge k; out_valid is high after edge k+N_DIGITS (8 cycles at default).
- No back-to-back overlap: in_ready rises the cycle after the result handshake. Initiation interval is N_DIGITS+2.
- in_valid is ignored outside IDLE. Operands are sampled only at the accept edge; later input changes have no effect.
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-RUN or in DONE: immediate abort to IDLE, all outputs to reset values, partial result discarded.
- Wrap-around: out_x is always the result mod 2^DATA_W; overflow is reported only via out_ovf.

Optional Feature:
- Macro: MUL23_RANGE_CHECK_EN.
- Defined: in_r is compared against 23 at the accept edge, and the flag is registered. out_err=1 with the DONE result when in_r >= 23; the computation still runs with the raw r. A simulation assertion fires if in_valid&in_ready with in_r > 22.
- Undefined: out_err is constant 0, with no comparator and no assertion.

Decomposition:
- Package div23_pkg holds:
  - constants DIVISOR=23, REM_W=5, DATA_W default;
  - state enum type (IDLE/RUN/DONE);
  - a function returning N_DIGITS for a given DIGIT_W.
- Sub-module mul23_digit: purely combinational (d, carry_in) -> (digit_out, carry_out), parameterised on DIGIT_W. The top level holds the FSM, shift registers and handshake.

Test Plan:
- q=0, r=0 -> out_x=0x00000000, ovf=0, err=0; out_valid exactly 8 cycles after accept.
- q=1, r=22 -> out_x=45 (0x2D), ovf=0.
- q=186737708, r=11 -> out_x=0xFFFFFFFF, ovf=0. Same q with r=12 -> out_x=0x00000000, ovf=1.
- q=0xFFFFFFFF, r=0 -> out_x=0xFFFFFFE9, ovf=1. Repeat with DIGIT_W=1, 2, 8 -> identical results, latency 32/16/4 cycles.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> out_x/out_ovf stable, in_ready=0; release -> in_ready=1 the next cycle.
  - Drop rst_n at RUN count=3 -> out_valid never asserts; a fresh q=2, r=1 gives 47.
- With MUL23_RANGE_CHECK_EN: q=5, r=23 -> out_x=138, err=1. Without the macro: same stimulus gives err=0.
